// File: rtl/lpif_rx_pkg.sv
// Shared widths, flit layout and link-state encoding for the LPIF upstream receive path.
package lpif_rx_pkg;

  localparam int LPIF_STATE_W  = 8;
  localparam int LPIF_PROTID_W = 4;
  localparam int LPIF_DATA_W   = 512;
  localparam int LPIF_CRC_W    = 16;
  localparam int LPIF_HALF_W   = 2;

  // state + protid + data + dvalid + crc + crc_valid + valid
  localparam int LPIF_FLIT_W = LPIF_STATE_W + LPIF_PROTID_W + LPIF_DATA_W +
                               LPIF_HALF_W + LPIF_CRC_W + LPIF_HALF_W + LPIF_HALF_W;

  // Field order is MSB first; this is exactly the layout presented on out_flit.
  typedef struct packed {
    logic [LPIF_STATE_W-1:0]  state;
    logic [LPIF_PROTID_W-1:0] protid;
    logic [LPIF_DATA_W-1:0]   data;
    logic [LPIF_HALF_W-1:0]   dvalid;
    logic [LPIF_CRC_W-1:0]    crc;
    logic [LPIF_HALF_W-1:0]   crc_valid;
    logic [LPIF_HALF_W-1:0]   valid;
  } lpif_flit_t;

  typedef enum logic {
    LINK_OFFLINE = 1'b0,
    LINK_ONLINE  = 1'b1
  } link_state_e;

endpackage

// File: rtl/lpif_sync_fifo_1clk.sv
// Single-clock FIFO whose head entry is held in a register (no fall-through),
// with a synchronous flush that empties it in one cycle.
module lpif_sync_fifo_1clk #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok, wr_en;

  assign empty = (fill_q == '0);
  assign full  = (fill_q == FW'(DEPTH));
  assign fill  = fill_q;
  assign dout  = head_q;

  // Pointer/fill update and next head selection; a push into a FIFO that is
  // (or becomes) empty this cycle bypasses the array straight into the head.
  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    fill_d   = fill_q + FW'(push_ok) - FW'(pop_ok);
    wr_en    = push_ok & ~flush;
    if (fill_d == '0) begin
      head_d = '0;
    end else if (push_ok && ((fill_q - FW'(pop_ok)) == '0)) begin
      head_d = din;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
      head_d   = '0;
    end
  end

  // Control state and registered head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      head_q   <= head_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/lpif_ustrm_rx_buffer.sv
// Captures LPIF upstream flits (no backpressure available) into a FIFO,
// presents them on valid/ready, returns one credit per consumed flit and
// tracks drops and link-state changes.
module lpif_ustrm_rx_buffer
  import lpif_rx_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6,
  parameter int FLIT_W    = LPIF_FLIT_W
) (
  input  logic                       clk_wr,
  input  logic                       rst_wr,
  input  logic                       rx_online,
  input  logic [LPIF_STATE_W-1:0]    ustrm_state,
  input  logic [LPIF_PROTID_W-1:0]   ustrm_protid,
  input  logic [LPIF_DATA_W-1:0]     ustrm_data,
  input  logic [LPIF_HALF_W-1:0]     ustrm_dvalid,
  input  logic [LPIF_CRC_W-1:0]      ustrm_crc,
  input  logic [LPIF_HALF_W-1:0]     ustrm_crc_valid,
  input  logic [LPIF_HALF_W-1:0]     ustrm_valid,
  output logic [FLIT_W-1:0]          out_flit,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       credit_return,
  output logic [$clog2(DEPTH):0]     rx_fill,
  output logic                       rx_afull,
  output logic                       rx_overflow,
  output logic [15:0]                rx_drop_cnt,
  output logic                       state_change,
  output logic [LPIF_STATE_W-1:0]    cur_state
);

  localparam int FW = $clog2(DEPTH) + 1;

  lpif_flit_t        in_flit;
  logic [FLIT_W-1:0] fifo_din;
  logic              fifo_full, fifo_empty;
  logic              capture_en, flush, push_req, pop, drop;

  link_state_e       link_q, link_d;
  logic              credit_q, credit_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic [LPIF_STATE_W-1:0] cur_state_q, cur_state_d;
  logic              state_change_q, state_change_d;

  assign in_flit = '{state:     ustrm_state,
                     protid:    ustrm_protid,
                     data:      ustrm_data,
                     dvalid:    ustrm_dvalid,
                     crc:       ustrm_crc,
                     crc_valid: ustrm_crc_valid,
                     valid:     ustrm_valid};
  assign fifo_din = in_flit;

  // Link FSM: capture is enabled on the rising cycle itself so the first
  // flit is not lost; any cycle spent offline flushes the buffer.
  always_comb begin
    link_d     = link_q;
    capture_en = 1'b0;
    flush      = 1'b0;
    case (link_q)
      LINK_OFFLINE: begin
        if (rx_online) begin
          link_d     = LINK_ONLINE;
          capture_en = 1'b1;
        end else begin
          flush = 1'b1;
        end
      end
      LINK_ONLINE: begin
        if (!rx_online) begin
          link_d = LINK_OFFLINE;
          flush  = 1'b1;
        end else begin
          capture_en = 1'b1;
        end
      end
      default: link_d = LINK_OFFLINE;
    endcase
  end

  // Flits without a valid half are never stored; a full FIFO only drops
  // when nothing leaves in the same cycle.
  always_comb begin
    push_req = capture_en & (|ustrm_valid);
    pop      = ~fifo_empty & out_ready;
    drop     = push_req & fifo_full & ~pop;
  end

  // Credit, drop statistics and link-state tracking.
  always_comb begin
    credit_d       = pop;
    overflow_d     = overflow_q | drop;
    drop_cnt_d     = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    cur_state_d    = cur_state_q;
    state_change_d = 1'b0;
    if (capture_en) begin
      cur_state_d    = ustrm_state;
      state_change_d = (ustrm_state != cur_state_q);
    end
  end

  // Registers for FSM and status outputs.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      link_q         <= LINK_OFFLINE;
      credit_q       <= 1'b0;
      overflow_q     <= 1'b0;
      drop_cnt_q     <= '0;
      cur_state_q    <= '0;
      state_change_q <= 1'b0;
    end else begin
      link_q         <= link_d;
      credit_q       <= credit_d;
      overflow_q     <= overflow_d;
      drop_cnt_q     <= drop_cnt_d;
      cur_state_q    <= cur_state_d;
      state_change_q <= state_change_d;
    end
  end

  lpif_sync_fifo_1clk #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_wr),
    .rst   (rst_wr),
    .push  (push_req),
    .din   (fifo_din),
    .pop   (pop),
    .flush (flush),
    .dout  (out_flit),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (rx_fill)
  );

  assign out_valid     = ~fifo_empty;
  assign rx_afull      = (rx_fill >= FW'(AFULL_LVL));
  assign credit_return = credit_q;
  assign rx_overflow   = overflow_q;
  assign rx_drop_cnt   = drop_cnt_q;
  assign state_change  = state_change_q;
  assign cur_state     = cur_state_q;

endmodule

// File: tb/tb_lpif_ustrm_rx_buffer.sv
// Randomized bench for lpif_ustrm_rx_buffer against a queue-based flit model.
module tb_lpif_ustrm_rx_buffer;

  localparam int DEPTH = 8;
  localparam int AFULL = 6;
  localparam int FW    = 546;

  logic          clk_wr = 1'b0;
  logic          rst_wr, rx_online, out_ready;
  logic [7:0]    ustrm_state;
  logic [3:0]    ustrm_protid;
  logic [511:0]  ustrm_data;
  logic [1:0]    ustrm_dvalid, ustrm_crc_valid, ustrm_valid;
  logic [15:0]   ustrm_crc;
  logic [FW-1:0] out_flit;
  logic          out_valid, credit_return, rx_afull, rx_overflow, state_change;
  logic [3:0]    rx_fill;
  logic [15:0]   rx_drop_cnt;
  logic [7:0]    cur_state;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [FW-1:0] mq[$];
  logic          m_credit, m_over, m_chg;
  int            m_drop;
  logic [7:0]    m_cur;

  always #5 clk_wr = ~clk_wr;

  lpif_ustrm_rx_buffer #(.DEPTH(DEPTH), .AFULL_LVL(AFULL), .FLIT_W(FW)) dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr), .rx_online(rx_online),
    .ustrm_state(ustrm_state), .ustrm_protid(ustrm_protid), .ustrm_data(ustrm_data),
    .ustrm_dvalid(ustrm_dvalid), .ustrm_crc(ustrm_crc), .ustrm_crc_valid(ustrm_crc_valid),
    .ustrm_valid(ustrm_valid), .out_flit(out_flit), .out_valid(out_valid),
    .out_ready(out_ready), .credit_return(credit_return), .rx_fill(rx_fill),
    .rx_afull(rx_afull), .rx_overflow(rx_overflow), .rx_drop_cnt(rx_drop_cnt),
    .state_change(state_change), .cur_state(cur_state)
  );

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [FW-1:0] cur_flit();
    return {ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid, ustrm_crc, ustrm_crc_valid, ustrm_valid};
  endfunction

  function automatic logic [FW-1:0] m_head();
    logic [FW-1:0] h;
    h = '0;
    if (mq.size() > 0) h = mq[0];
    return h;
  endfunction

  // Side-band fields are randomized with dvalid/crc_valid non-zero so that
  // valid=0 flits still look "busy".
  task automatic set_in(input logic on, input logic [1:0] v, input logic rdy,
                        input logic [7:0] st, input logic [511:0] d);
    rx_online       = on;
    ustrm_valid     = v;
    out_ready       = rdy;
    ustrm_state     = st;
    ustrm_data      = d;
    ustrm_protid    = 4'($urandom);
    ustrm_crc       = 16'($urandom);
    ustrm_dvalid    = 2'($urandom_range(1, 3));
    ustrm_crc_valid = 2'($urandom_range(1, 3));
  endtask

  // One clock edge; the model applies the rules to the inputs seen at the edge.
  task automatic cycle();
    logic pop;
    @(posedge clk_wr);
    if (rst_wr) begin
      mq.delete();
      m_credit = 1'b0; m_over = 1'b0; m_drop = 0; m_cur = '0; m_chg = 1'b0;
    end else begin
      pop = out_ready && (mq.size() > 0);
      m_credit = pop;
      if (pop) void'(mq.pop_front());
      if (!rx_online) begin
        mq.delete();
        m_chg = 1'b0;
      end else begin
        m_chg = (ustrm_state != m_cur);
        m_cur = ustrm_state;
        if (ustrm_valid != 2'b00) begin
          if (mq.size() < DEPTH) mq.push_back(cur_flit());
          else begin
            m_over = 1'b1;
            if (m_drop < 65535) m_drop++;
          end
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_wr = 1'b1;
    set_in(1'b0, 2'b00, 1'b0, 8'h00, '0);
    cycle();
    rst_wr = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [7:0] st);
    for (int i = 0; i < n; i++) begin
      set_in(1'b1, 2'($urandom_range(1, 3)), 1'b0, st, rand512());
      cycle();
    end
  endtask

  task automatic test_reset();
    rst_wr = 1'b1;
    set_in(1'b1, 2'b11, 1'b1, 8'hA5, rand512());
    cycle();
    rst_wr = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (out_flit !== '0) begin failures++; $display("FAIL reset_out_flit got=%0h exp=0", out_flit); end
    checks++; if (credit_return !== 1'b0) begin failures++; $display("FAIL reset_credit got=%0h exp=0", credit_return); end
    checks++; if (rx_fill !== 4'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", rx_fill); end
    checks++; if (rx_afull !== 1'b0) begin failures++; $display("FAIL reset_afull got=%0h exp=0", rx_afull); end
    checks++; if (rx_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0h exp=0", rx_overflow); end
    checks++; if (rx_drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", rx_drop_cnt); end
    checks++; if (state_change !== 1'b0) begin failures++; $display("FAIL reset_state_change got=%0h exp=0", state_change); end
    checks++; if (cur_state !== 8'h00) begin failures++; $display("FAIL reset_cur_state got=%0h exp=0", cur_state); end
  endtask

  task automatic test_basic();
    int credits, peak;
    do_reset();
    set_in(1'b1, 2'b00, 1'b1, 8'h10, '0);
    cycle();
    credits = 0; peak = 0;
    for (int i = 1; i <= 3; i++) begin
      set_in(1'b1, 2'b11, 1'b1, 8'h10, 512'(i));
      cycle();
      credits += int'(credit_return);
      if (int'(rx_fill) > peak) peak = int'(rx_fill);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid[%0d] got=%0h exp=1", i, out_valid); end
      checks++; if (out_flit[533:22] !== 512'(i)) begin failures++; $display("FAIL basic_data[%0d] got=%0h exp=%0h", i, out_flit[533:22], i); end
      checks++; if (out_flit !== m_head()) begin failures++; $display("FAIL basic_flit[%0d] got=%0h exp=%0h", i, out_flit, m_head()); end
    end
    set_in(1'b1, 2'b00, 1'b1, 8'h10, '0);
    cycle();
    credits += int'(credit_return);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drained got=%0h exp=0", out_valid); end
    checks++; if (credits != 3) begin failures++; $display("FAIL basic_credits got=%0d exp=3", credits); end
    checks++; if (peak != 1) begin failures++; $display("FAIL basic_peak_fill got=%0d exp=1", peak); end
  endtask

  task automatic test_overflow();
    logic [FW-1:0] sent[10];
    int ef;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 2'($urandom_range(1, 3)), 1'b0, 8'h20, rand512());
      sent[i] = cur_flit();
      cycle();
      ef = (i + 1 < DEPTH) ? i + 1 : DEPTH;
      checks++; if (rx_fill !== 4'(ef)) begin failures++; $display("FAIL ovf_fill[%0d] got=%0d exp=%0d", i, rx_fill, ef); end
      checks++; if (rx_afull !== (ef >= AFULL)) begin failures++; $display("FAIL ovf_afull[%0d] got=%0h exp=%0h", i, rx_afull, ef >= AFULL); end
    end
    checks++; if (rx_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0h exp=1", rx_overflow); end
    checks++; if (rx_drop_cnt !== 16'd2) begin failures++; $display("FAIL ovf_drop_cnt got=%0d exp=2", rx_drop_cnt); end
    for (int k = 0; k < DEPTH; k++) begin
      checks++; if (out_flit !== sent[k]) begin failures++; $display("FAIL ovf_order[%0d] got=%0h exp=%0h", k, out_flit, sent[k]); end
      set_in(1'b1, 2'b00, 1'b1, 8'h20, '0);
      cycle();
      checks++; if (credit_return !== 1'b1) begin failures++; $display("FAIL ovf_credit[%0d] got=%0h exp=1", k, credit_return); end
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%0h exp=0", out_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [FW-1:0] sent[9];
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 2'b01, 1'b0, 8'h30, rand512());
      sent[i] = cur_flit();
      cycle();
    end
    set_in(1'b1, 2'b10, 1'b1, 8'h30, rand512());
    sent[8] = cur_flit();
    cycle();
    checks++; if (rx_fill !== 4'd8) begin failures++; $display("FAIL fpp_fill got=%0d exp=8", rx_fill); end
    checks++; if (rx_drop_cnt !== 16'd0) begin failures++; $display("FAIL fpp_drop got=%0d exp=0", rx_drop_cnt); end
    checks++; if (rx_overflow !== 1'b0) begin failures++; $display("FAIL fpp_overflow got=%0h exp=0", rx_overflow); end
    checks++; if (credit_return !== 1'b1) begin failures++; $display("FAIL fpp_credit got=%0h exp=1", credit_return); end
    checks++; if (out_flit !== sent[1]) begin failures++; $display("FAIL fpp_head got=%0h exp=%0h", out_flit, sent[1]); end
    set_in(1'b1, 2'b00, 1'b0, 8'h30, '0);
    cycle();
    checks++; if (credit_return !== 1'b0) begin failures++; $display("FAIL fpp_single_pulse got=%0h exp=0", credit_return); end
    for (int k = 1; k < 9; k++) begin
      checks++; if (out_flit !== sent[k]) begin failures++; $display("FAIL fpp_order[%0d] got=%0h exp=%0h", k, out_flit, sent[k]); end
      set_in(1'b1, 2'b00, 1'b1, 8'h30, '0);
      cycle();
    end
  endtask

  task automatic test_flush();
    int credits;
    do_reset();
    push_n(10, 8'h40);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 2'b00, 1'b1, 8'h40, '0);
      cycle();
    end
    checks++; if (rx_fill !== 4'd4) begin failures++; $display("FAIL flush_pre_fill got=%0d exp=4", rx_fill); end
    set_in(1'b0, 2'b11, 1'b0, 8'h40, rand512());
    cycle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0h exp=0", out_valid); end
    checks++; if (rx_fill !== 4'd0) begin failures++; $display("FAIL flush_fill got=%0d exp=0", rx_fill); end
    checks++; if (rx_drop_cnt !== 16'd2) begin failures++; $display("FAIL flush_drop_kept got=%0d exp=2", rx_drop_cnt); end
    checks++; if (rx_overflow !== 1'b1) begin failures++; $display("FAIL flush_ovf_kept got=%0h exp=1", rx_overflow); end
    credits = int'(credit_return);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 2'b00, 1'b1, 8'h40, '0);
      cycle();
      credits += int'(credit_return);
    end
    checks++; if (credits != 0) begin failures++; $display("FAIL flush_no_credit got=%0d exp=0", credits); end
    push_n(2, 8'h40);
    set_in(1'b0, 2'b00, 1'b1, 8'h40, '0);
    cycle();
    checks++; if (credit_return !== 1'b1) begin failures++; $display("FAIL flush_pop_credit got=%0h exp=1", credit_return); end
    checks++; if (rx_fill !== 4'd0) begin failures++; $display("FAIL flush_pop_fill got=%0d exp=0", rx_fill); end
  endtask

  task automatic test_state();
    logic [7:0] seq[3];
    int pulses;
    seq[0] = 8'h01; seq[1] = 8'h01; seq[2] = 8'h03;
    do_reset();
    set_in(1'b1, 2'b00, 1'b0, 8'h01, rand512());
    cycle();
    checks++; if (state_change !== 1'b1) begin failures++; $display("FAIL state_prime got=%0h exp=1", state_change); end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 2'b00, 1'b0, seq[i], rand512());
      cycle();
      pulses += int'(state_change);
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL state_pulses got=%0d exp=1", pulses); end
    checks++; if (cur_state !== 8'h03) begin failures++; $display("FAIL state_cur got=%0h exp=03", cur_state); end
    checks++; if (rx_fill !== 4'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL state_no_push got=%0d exp=0", rx_fill); end
    set_in(1'b0, 2'b00, 1'b0, 8'h55, '0);
    cycle();
    checks++; if (cur_state !== 8'h03) begin failures++; $display("FAIL state_offline_hold got=%0h exp=03", cur_state); end
    checks++; if (state_change !== 1'b0) begin failures++; $display("FAIL state_offline_pulse got=%0h exp=0", state_change); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    push_n(10, 8'h60);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 2'b00, 1'b1, 8'h60, '0);
      cycle();
    end
    checks++; if (rx_fill !== 4'd5 || rx_overflow !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0d/%0h exp=5/1", rx_fill, rx_overflow); end
    rst_wr = 1'b1;
    set_in(1'b1, 2'b11, 1'b1, 8'h61, rand512());
    cycle();
    rst_wr = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_flit !== '0) begin failures++; $display("FAIL mid_out got=%0h exp=0", out_valid); end
    checks++; if (credit_return !== 1'b0) begin failures++; $display("FAIL mid_credit got=%0h exp=0", credit_return); end
    checks++; if (rx_fill !== 4'd0 || rx_afull !== 1'b0) begin failures++; $display("FAIL mid_fill got=%0d exp=0", rx_fill); end
    checks++; if (rx_overflow !== 1'b0 || rx_drop_cnt !== 16'd0) begin failures++; $display("FAIL mid_stats got=%0h/%0d exp=0/0", rx_overflow, rx_drop_cnt); end
    checks++; if (state_change !== 1'b0 || cur_state !== 8'h00) begin failures++; $display("FAIL mid_state got=%0h/%0h exp=0/0", state_change, cur_state); end
    set_in(1'b0, 2'b00, 1'b1, 8'h00, '0);
    cycle();
    checks++; if (credit_return !== 1'b0) begin failures++; $display("FAIL mid_post_credit got=%0h exp=0", credit_return); end
  endtask

  task automatic test_random();
    int rdy_pct;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rdy_pct = (n < 300) ? 25 : 75;
      set_in(($urandom_range(0, 99) < 92), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 99) < rdy_pct), 8'($urandom_range(0, 3)), rand512());
      cycle();
      checks++; if (out_valid !== (mq.size() > 0)) begin failures++; $display("FAIL rnd_valid[%0d] got=%0h exp=%0h", n, out_valid, mq.size() > 0); end
      checks++; if (out_flit !== m_head()) begin failures++; $display("FAIL rnd_flit[%0d] got=%0h exp=%0h", n, out_flit, m_head()); end
      checks++; if (rx_fill !== 4'(mq.size())) begin failures++; $display("FAIL rnd_fill[%0d] got=%0d exp=%0d", n, rx_fill, mq.size()); end
      checks++; if (rx_afull !== (mq.size() >= AFULL)) begin failures++; $display("FAIL rnd_afull[%0d] got=%0h exp=%0h", n, rx_afull, mq.size() >= AFULL); end
      checks++; if (credit_return !== m_credit) begin failures++; $display("FAIL rnd_credit[%0d] got=%0h exp=%0h", n, credit_return, m_credit); end
      checks++; if (rx_overflow !== m_over) begin failures++; $display("FAIL rnd_overflow[%0d] got=%0h exp=%0h", n, rx_overflow, m_over); end
      checks++; if (rx_drop_cnt !== 16'(m_drop)) begin failures++; $display("FAIL rnd_drop[%0d] got=%0d exp=%0d", n, rx_drop_cnt, m_drop); end
      checks++; if (state_change !== m_chg) begin failures++; $display("FAIL rnd_chg[%0d] got=%0h exp=%0h", n, state_change, m_chg); end
      checks++; if (cur_state !== m_cur) begin failures++; $display("FAIL rnd_cur[%0d] got=%0h exp=%0h", n, cur_state, m_cur); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_wr = 1'b1;
    set_in(1'b0, 2'b00, 1'b0, 8'h00, '0);
    m_credit = 1'b0; m_over = 1'b0; m_drop = 0; m_cur = '0; m_chg = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_state();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lpif_ustrm_rx_buffer.md
Name: lpif_ustrm_rx_buffer

Overview:
- Sits directly downstream of the LPIF x8 asym1 half-master top and consumes its upstream-channel outputs (ustrm_*).
- The LPIF upstream channel has no ready or backpressure, so this block captures every valid flit into a single-clock FIFO. It presents the flits to the protocol layer on a valid/ready interface.
- Detects overflow and counts dropped flits, tracks link-state changes, and returns one credit pulse per consumed flit. The credit pulses feed the far-end credit accounting.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- AFULL_LVL, 6, fill level at or above which rx_afull asserts; must be less than or equal to DEPTH.
- FLIT_W, 546, stored flit width: state 8 + protid 4 + data 512 + dvalid 2 + crc 16 + crc_valid 2 + valid 2.

Ports:
- clk_wr  in  1  single clock.
- rst_wr  in  1  reset, synchronous, active-high.
- rx_online  in  1  link online; when low, no capture occurs and the FIFO is flushed.
- ustrm_state  in  8  LPIF link state.
- ustrm_protid  in  4  protocol ID.
- ustrm_data  in  512  flit data.
- ustrm_dvalid  in  2  per-half data valid.
- ustrm_crc  in  16  CRC.
- ustrm_crc_valid  in  2  CRC valid.
- ustrm_valid  in  2  per-half flit valid.
- out_flit  out  FLIT_W  head flit, packed in the field order listed under FLIT_W, MSB first.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head flit.
- credit_return  out  1  one-cycle pulse per popped flit.
- rx_fill  out  $clog2(DEPTH)+1  current occupancy.
- rx_afull  out  1  rx_fill is at or above AFULL_LVL.
- rx_overflow  out  1  sticky; set on the first dropped flit.
- rx_drop_cnt  out  16  saturating count of dropped flits.
- state_change  out  1  one-cycle pulse when ustrm_state differs from the last captured state.
- cur_state  out  8  last registered ustrm_state.

Behaviour:
- Reset (rst_wr high at a clk_wr edge):
  - Pointers and fill are cleared.
  - out_valid=0, out_flit=0, credit_return=0, rx_fill=0, rx_afull=0, rx_overflow=0, rx_drop_cnt=0, state_change=0, cur_state=0.
  - Reset asserted mid-stream discards all buffered flits and does not pulse credit_return.
- Push condition: push_req = rx_online & |ustrm_valid.
  - The full input bundle is written as one entry.
  - A flit with ustrm_valid=0 is never stored, even when dvalid or crc_valid is set.
- Pop condition: pop = out_valid & out_ready.
  - credit_return is registered and pulses in the cycle after the pop.
  - out_ready while empty is ignored and produces no credit.
- Latency: a flit pushed at edge N appears on out_flit/out_valid after edge N. That is one cycle, and it also holds for an empty FIFO (no fall-through).
  - out_flit is the registered head entry and holds stable while out_valid=1 and out_ready=0.
- Full FIFO:
  - push_req with no pop in the same cycle: the flit is dropped, rx_overflow is set, and rx_drop_cnt increments, saturating at 16'hFFFF.
  - push_req with a pop in the same cycle: the push is accepted, fill stays at DEPTH, and nothing is dropped.
- Empty FIFO with a simultaneous push and pop: the pop is ignored because out_valid=0, and the push is accepted.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. rx_fill is updated as rx_fill + push_accepted - pop.
- rx_online falling edge, or rx_online low:
  - In every cycle with rx_online=0, the FIFO flushes (fill becomes 0, out_valid becomes 0), and flushed flits produce no credit.
  - A pop in the same cycle as the flush still pulses credit_return, because the consumer took that flit.
  - rx_overflow and rx_drop_cnt are retained; only rst_wr clears them.
- State tracking:
  - cur_state registers ustrm_state every cycle that rx_online=1.
  - state_change pulses for one cycle when the newly registered value differs from the previous cur_state.
  - State tracking is independent of ustrm_valid.
- Link-state FSM (2 states):
  - OFFLINE to ONLINE when rx_online=1.
  - ONLINE to OFFLINE when rx_online=0, which triggers the flush.
  - Capture occurs only in ONLINE or on the transition cycle into it. The first flit is captured in the same cycle that rx_online rises.

Decomposition:
- Package lpif_rx_pkg holds:
  - Width constants: LPIF_STATE_W=8, LPIF_PROTID_W=4, LPIF_DATA_W=512, LPIF_CRC_W=16, LPIF_HALF_W=2.
  - Derived LPIF_FLIT_W=546.
  - Packed struct typedef lpif_flit_t.
- Sub-module lpif_sync_fifo_1clk: a generic single-clock FIFO with registered output, parameters WIDTH and DEPTH, and push/pop/flush/full/empty/fill ports.
- The top level adds the drop logic, credit, state tracking and FSM.

Test Plan:
- Reset, then rx_online=1, then 3 flits with ustrm_valid=2'b11 and data=1,2,3 while out_ready=1. Required: out_flit data 1,2,3 in order, each one cycle after its push; 3 credit_return pulses; rx_fill peaks at 1.
- out_ready=0, then 10 flits pushed into DEPTH=8. Required: rx_fill=8; rx_afull asserted from fill 6; rx_overflow=1; rx_drop_cnt=2; the first 8 flits pop intact once out_ready=1.
- FIFO full, push and pop in the same cycle. Required: no drop, rx_fill stays 8, one credit_return pulse.
- 4 flits buffered, then rx_online drops for 1 cycle. Required: out_valid=0 and rx_fill=0 the next cycle; no credit pulses for the flushed flits; rx_drop_cnt unchanged.
- ustrm_state sequence 8'h01, 8'h01, 8'h03 with ustrm_valid=0. Required: exactly one state_change pulse; cur_state=8'h03; no push.
- rst_wr asserted with 5 flits buffered and rx_overflow=1. Required: every output returns to its reset value on the next edge, with no credit pulse.
